// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity modes,
// baud divisor and bit-vote helpers.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_BREAK  = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud,
                                           int unsigned os);
    int unsigned den;
    int unsigned q;
    den = baud * os;
    q   = (clk_hz + den / 2) / den;
    return (q == 0) ? 1 : q;
  endfunction

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head entry.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with 3-sample majority vote, runtime parity,
// sticky error flags and a FWFT word buffer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          par_en,
  input  logic                          par_odd,
  input  logic                          rx_rd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          par_err,
  output logic                          overrun,
  input  logic                          err_clr
);
  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PHW = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int BCW = $clog2(DATA_BITS + 1);

  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DCW-1:0]       div_q, div_d;
  state_t               state_q, state_d;
  logic [PHW-1:0]       ph_q, ph_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           smp_q, smp_d;
  logic                 par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                 par_bad_q, par_bad_d, stop_bad_q, stop_bad_d;
  logic                 frame_err_q, frame_err_d, par_err_q, par_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, maj, stop_bad_now, push_w, fe_set, pe_set;
  logic                 fifo_empty, fifo_full;

  assign tick = (div_q == DCW'(DIV - 1));
  assign maj  = maj3(smp_q[1], smp_q[0], sync2_q);

  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    smp_d      = smp_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    stop_bad_now = stop_bad_q | ~maj;
    push_w     = 1'b0;
    fe_set     = 1'b0;
    pe_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
          ph_d    = '0;
        end
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: begin
        if (tick) begin
          ph_d = (ph_q == PHW'(OVERSAMPLE - 1)) ? '0 : ph_q + 1'b1;
          if (ph_q == PHW'(M - 1)) smp_d[1] = sync2_q;
          if (ph_q == PHW'(M))     smp_d[0] = sync2_q;
          // Third vote is the live sample; every bit decision lands here.
          if (ph_q == PHW'(M + 1)) begin
            case (state_q)
              ST_START: begin
                if (!maj) begin
                  state_d    = ST_DATA;
                  bit_d      = '0;
                  par_en_d   = par_en;
                  par_odd_d  = par_odd ? PAR_ODD : PAR_EVEN;
                  par_bad_d  = 1'b0;
                  stop_bad_d = 1'b0;
                end else begin
                  state_d = ST_IDLE;
                end
              end
              ST_DATA: begin
                shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_q == BCW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                  bit_d = bit_q + 1'b1;
                end
              end
              ST_PARITY: begin
                par_bad_d = maj ^ (^shift_q) ^ (par_odd_q == PAR_ODD);
                state_d   = ST_STOP;
              end
              ST_STOP: begin
                if (bit_q == BCW'(STOP_BITS - 1)) begin
                  push_w  = !stop_bad_now && !par_bad_q;
                  fe_set  = stop_bad_now;
                  pe_set  = par_bad_q;
                  state_d = stop_bad_now ? ST_BREAK : ST_IDLE;
                end else begin
                  stop_bad_d = stop_bad_now;
                  bit_d      = bit_q + 1'b1;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase

    frame_err_d = (frame_err_q & ~err_clr) | fe_set;
    par_err_d   = (par_err_q & ~err_clr) | pe_set;
    overrun_d   = (overrun_q & ~err_clr) | (push_w & fifo_full & ~rx_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      div_q       <= '0;
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      smp_q       <= 2'b11;
      par_en_q    <= 1'b0;
      par_odd_q   <= PAR_EVEN;
      par_bad_q   <= 1'b0;
      stop_bad_q  <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      div_q       <= div_d;
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      smp_q       <= smp_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      par_bad_q   <= par_bad_d;
      stop_bad_q  <= stop_bad_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_w),
    .wr_data (shift_q),
    .rd_en   (rx_rd),
    .rd_data (rx_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (rx_count)
  );

  assign rx_ready  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign par_err   = par_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table of single frames, hand-built corner sequences,
// then random traffic checked against a queue model.
module tb_uart_rx_fifo;
  localparam int CLK_HZ = 3_200_000;
  localparam int BAUD   = 100_000;
  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int SB     = 1;
  localparam int DEPTH  = 4;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic par_en = 1'b0, par_odd = 1'b0, rx_rd = 1'b0, err_clr = 1'b0;
  logic [DB-1:0]            rx_data;
  logic                     rx_ready, frame_err, par_err, overrun;
  logic [$clog2(DEPTH):0]   rx_count;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB),
                 .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .par_en(par_en), .par_odd(par_odd), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err),
    .par_err(par_err), .overrun(overrun), .err_clr(err_clr));

  typedef struct {
    logic [7:0] d;
    bit pe, po, flip, stop;
    bit exp_store, exp_fe, exp_pe;
  } vec_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic v);
    rx = v;
    cyc(BIT);
  endtask

  function automatic bit par_bit(logic [7:0] d, bit po, bit flip);
    return bit'($countones(d) % 2) ^ po ^ flip;
  endfunction

  // flip_cfg toggles par_en/par_odd in the middle of the data bits.
  task automatic send_frame(logic [7:0] d, bit pen, bit pb, bit stop, bit flip_cfg);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) begin
      if (flip_cfg && i == 3) begin
        par_en  = ~par_en;
        par_odd = ~par_odd;
      end
      send_bit(d[i]);
    end
    if (pen) send_bit(pb);
    send_bit(stop);
    rx = 1'b1;
    cyc(2 * BIT);
  endtask

  task automatic pop_chk(string nm, logic [7:0] exp);
    chk(nm, rx_data, exp);
    rx_rd = 1'b1;
    cyc(1);
    rx_rd = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic chk_state(string nm, int cnt, bit fe, bit pe, bit ov);
    chk({nm, "_count"}, rx_count, cnt);
    chk({nm, "_ready"}, rx_ready, cnt != 0);
    chk({nm, "_fe"}, frame_err, fe);
    chk({nm, "_pe"}, par_err, pe);
    chk({nm, "_ov"}, overrun, ov);
  endtask

  // Finds the commit cycle, optionally pops on it, and checks 1-clk visibility.
  task automatic watch_commit(bit do_rd, bit ready_before);
    bit seen = 1'b0;
    for (int n = 0; n < 16 * BIT && !seen; n++) begin
      @(negedge clk);
      if (dut.push_w === 1'b1) seen = 1'b1;
    end
    chk("commit_seen", seen, 1);
    if (seen) begin
      chk("ready_at_commit", rx_ready, ready_before);
      if (do_rd) rx_rd = 1'b1;
      @(posedge clk);
      #1;
      rx_rd = 1'b0;
      chk("ready_after_commit", rx_ready, 1);
    end
  endtask

  vec_t vecs[8];
  logic [7:0] q[$];
  bit efe, epe, eov;

  initial begin
    vecs[0] = '{d:8'hA5, pe:0, po:0, flip:0, stop:1, exp_store:1, exp_fe:0, exp_pe:0};
    vecs[1] = '{d:8'h03, pe:1, po:0, flip:1, stop:1, exp_store:0, exp_fe:0, exp_pe:1};
    vecs[2] = '{d:8'h03, pe:1, po:0, flip:0, stop:1, exp_store:1, exp_fe:0, exp_pe:0};
    vecs[3] = '{d:8'h5A, pe:1, po:1, flip:0, stop:1, exp_store:1, exp_fe:0, exp_pe:0};
    vecs[4] = '{d:8'h5A, pe:1, po:1, flip:1, stop:1, exp_store:0, exp_fe:0, exp_pe:1};
    vecs[5] = '{d:8'h00, pe:0, po:0, flip:0, stop:0, exp_store:0, exp_fe:1, exp_pe:0};
    vecs[6] = '{d:8'hFF, pe:1, po:0, flip:1, stop:0, exp_store:0, exp_fe:1, exp_pe:1};
    vecs[7] = '{d:8'h80, pe:1, po:1, flip:0, stop:1, exp_store:1, exp_fe:0, exp_pe:0};

    cyc(3);
    chk("rst_data", rx_data, 0);
    chk_state("rst", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2 * BIT);

    foreach (vecs[i]) begin
      par_en  = vecs[i].pe;
      par_odd = vecs[i].po;
      send_frame(vecs[i].d, vecs[i].pe, par_bit(vecs[i].d, vecs[i].po, vecs[i].flip),
                 vecs[i].stop, 1'b0);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_store, vecs[i].exp_fe,
                vecs[i].exp_pe, 0);
      if (vecs[i].exp_store) pop_chk($sformatf("vec%0d_data", i), vecs[i].d);
      clr_err();
    end
    par_en  = 1'b0;
    par_odd = 1'b0;

    // Stop bit low followed by a long break, then a clean word.
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(i[0] == 1'b0);
    rx = 1'b0;
    cyc(21 * BIT);
    rx = 1'b1;
    cyc(2 * BIT);
    send_frame(8'h12, 0, 0, 1, 0);
    chk_state("break", 1, 1, 0, 0);
    pop_chk("break_data", 8'h12);
    clr_err();

    // Overflow: fifth word dropped.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 1, 0);
    chk_state("ovf", DEPTH, 0, 0, 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf_rd%0d", i), 8'(i));
    chk("ovf_empty", rx_count, 0);
    clr_err();

    // Full FIFO with a pop on the commit cycle: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 0, 0, 1, 0);
    fork
      send_frame(8'h15, 0, 0, 1, 0);
      watch_commit(1'b1, 1'b1);
    join
    chk_state("full_rd", DEPTH, 0, 0, 0);
    for (int i = 2; i <= 5; i++) pop_chk($sformatf("full_rd%0d", i), 8'h10 + 8'(i));

    // Quarter-bit glitch is rejected.
    rx = 1'b0;
    cyc(BIT / 4);
    rx = 1'b1;
    cyc(3 * BIT);
    chk_state("glitch", 0, 0, 0, 0);

    // Parity config is latched when the start bit is accepted.
    par_en  = 1'b1;
    par_odd = 1'b1;
    send_frame(8'h6B, 1, par_bit(8'h6B, 1, 0), 1, 1);
    chk_state("latch_cfg", 1, 0, 0, 0);
    pop_chk("latch_cfg_data", 8'h6B);
    par_en  = 1'b0;
    par_odd = 1'b0;

    // Reset mid-frame with state to clear, then a clean frame.
    send_frame(8'h77, 0, 0, 1, 0);
    send_frame(8'h01, 0, 0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    cyc(3);
    chk("mid_rst_data", rx_data, 0);
    chk_state("mid_rst", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2 * BIT);
    fork
      send_frame(8'h3C, 0, 0, 1, 0);
      watch_commit(1'b0, 1'b0);
    join
    chk_state("post_rst", 1, 0, 0, 0);
    pop_chk("post_rst_data", 8'h3C);

    // Random traffic against a queue model.
    efe = 0; epe = 0; eov = 0;
    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      bit pe, po, bp, bs;
      int nr;
      d  = 8'($urandom);
      pe = bit'($urandom_range(0, 1));
      po = bit'($urandom_range(0, 1));
      bp = pe && ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0);
      par_en  = pe;
      par_odd = po;
      send_frame(d, pe, par_bit(d, po, bp), !bs, 1'b0);
      if (bs) efe = 1;
      if (bp) epe = 1;
      if (!bs && !bp) begin
        if (q.size() == DEPTH) eov = 1;
        else q.push_back(d);
      end
      chk_state($sformatf("rnd%0d", k), q.size(), efe, epe, eov);
      if ($urandom_range(0, 2) == 0) begin
        clr_err();
        efe = 0; epe = 0; eov = 0;
      end
      nr = $urandom_range(0, q.size());
      for (int j = 0; j < nr; j++) pop_chk($sformatf("rnd%0d_rd", k), q.pop_front());
    end
    while (q.size() > 0) pop_chk("rnd_drain", q.pop_front());
    chk("rnd_final_count", rx_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
